// File: rtl/ex_mem.sv
// ex_mem: EX -> MEM pipeline register for the 64-bit 5-stage core.
// It captures the EX control bits, the ALU result, the store data and the
// destination register index on every rising edge. Every output comes
// straight from a flop.
// Optional macro EX_MEM_HAZARD_EN adds the stall (hold) and flush (bubble)
// inputs. Priority on each edge is reset > flush > stall > load.
module ex_mem #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] AluResult,
    input  logic [DATA_W-1:0] Datain,
    input  logic [REG_W-1:0]  Rd_in,
`ifdef EX_MEM_HAZARD_EN
    input  logic              stall,
    input  logic              flush,
`endif
    output logic              RegWrite_Out,
    output logic              MemtoReg_Out,
    output logic              MemWrite_Out,
    output logic [DATA_W-1:0] AluOut,
    output logic [DATA_W-1:0] DataOut,
    output logic [REG_W-1:0]  Rd_out
);

    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [REG_W-1:0]  rd_q, rd_d;

    // Next-state selection. The default is a plain load. A flush keeps the
    // data fields but kills the control bits, so the bubble cannot write
    // memory or the register file.
    always_comb begin
        reg_write_d  = RegWrite;
        mem_to_reg_d = MemtoReg;
        mem_write_d  = MemWrite;
        alu_d        = AluResult;
        data_d       = Datain;
        rd_d         = Rd_in;
`ifdef EX_MEM_HAZARD_EN
        if (flush) begin
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            mem_write_d  = 1'b0;
        end else if (stall) begin
            reg_write_d  = reg_write_q;
            mem_to_reg_d = mem_to_reg_q;
            mem_write_d  = mem_write_q;
            alu_d        = alu_q;
            data_d       = data_q;
            rd_d         = rd_q;
        end
`endif
    end

    // Pipeline state. A synchronous reset clears every field.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_q        <= '0;
            data_q       <= '0;
            rd_q         <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            alu_q        <= alu_d;
            data_q       <= data_d;
            rd_q         <= rd_d;
        end
    end

    assign RegWrite_Out = reg_write_q;
    assign MemtoReg_Out = mem_to_reg_q;
    assign MemWrite_Out = mem_write_q;
    assign AluOut       = alu_q;
    assign DataOut      = data_q;
    assign Rd_out       = rd_q;

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem.
// The reference model holds the value that each output should have after
// the next edge. It is rebuilt from the reset > flush > stall > load rules.
// The hazard cases run only when EX_MEM_HAZARD_EN is defined.
module tb_ex_mem;
    localparam int DATA_W = 64;
    localparam int REG_W  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              RegWrite, MemtoReg, MemWrite;
    logic [DATA_W-1:0] AluResult, Datain;
    logic [REG_W-1:0]  Rd_in;
    logic              stall, flush;
    logic              RegWrite_Out, MemtoReg_Out, MemWrite_Out;
    logic [DATA_W-1:0] AluOut, DataOut;
    logic [REG_W-1:0]  Rd_out;

    int checks   = 0;
    int failures = 0;

    // Model of the expected output state.
    logic              e_rw, e_mr, e_mw;
    logic [DATA_W-1:0] e_alu, e_dat;
    logic [REG_W-1:0]  e_rd;

    always #5 clk = ~clk;

    ex_mem #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .reset(reset),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
        .AluResult(AluResult), .Datain(Datain), .Rd_in(Rd_in),
`ifdef EX_MEM_HAZARD_EN
        .stall(stall), .flush(flush),
`endif
        .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out),
        .MemWrite_Out(MemWrite_Out), .AluOut(AluOut), .DataOut(DataOut),
        .Rd_out(Rd_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".rw"},  64'(RegWrite_Out), 64'(e_rw));
        chk({tag, ".mr"},  64'(MemtoReg_Out), 64'(e_mr));
        chk({tag, ".mw"},  64'(MemWrite_Out), 64'(e_mw));
        chk({tag, ".alu"}, AluOut, e_alu);
        chk({tag, ".dat"}, DataOut, e_dat);
        chk({tag, ".rd"},  64'(Rd_out), 64'(e_rd));
    endtask

    // Update the model from the inputs currently applied, run one edge,
    // then sample 1ns after the edge.
    task automatic step(input string tag);
        if (reset) begin
            {e_rw, e_mr, e_mw} = 3'b000;
            e_alu = '0; e_dat = '0; e_rd = '0;
        end else if (flush) begin
            {e_rw, e_mr, e_mw} = 3'b000;
            e_alu = AluResult; e_dat = Datain; e_rd = Rd_in;
        end else if (!stall) begin
            e_rw = RegWrite; e_mr = MemtoReg; e_mw = MemWrite;
            e_alu = AluResult; e_dat = Datain; e_rd = Rd_in;
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic drive(input logic rw, input logic mr, input logic mw,
                         input logic [63:0] alu, input logic [63:0] dat,
                         input logic [4:0] rd);
        RegWrite = rw; MemtoReg = mr; MemWrite = mw;
        AluResult = alu; Datain = dat; Rd_in = rd;
    endtask

    initial begin
        stall = 1'b0; flush = 1'b0;
        reset = 1'b1;
        drive(1, 1, 1, 64'h55, 64'h66, 5'd7);
        step("reset");
        reset = 1'b0;
        drive(0, 0, 0, 64'h0, 64'h0, 5'd0);
        step("zero");

        // All-ones load. Outputs must not change until the edge.
        drive(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_0123_4567, 5'd31);
        #2;
        chk_all("ones_pre");
        step("ones");

        // Back-to-back transfers.
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, 0, 64'(i * 16), 64'(i), 5'(i));
            step($sformatf("b2b%0d", i));
            chk("b2b_rd", 64'(Rd_out), 64'(i));
        end

        // Reset raised and dropped between edges has no effect.
        drive(1, 0, 1, 64'h1234, 64'h9, 5'd4);
        step("hold1234");
        reset = 1'b1; #2;
        chk_all("midrst_glitch");
        reset = 1'b0;
        // Reset at the edge with nonzero inputs, then the next edge loads.
        reset = 1'b1;
        drive(1, 1, 1, 64'h777, 64'h888, 5'd9);
        step("midrst");
        reset = 1'b0;
        step("post_rst");

`ifdef EX_MEM_HAZARD_EN
        drive(1, 0, 0, 64'hA5, 64'h1, 5'd3);
        step("pre_stall");
        stall = 1'b1;
        drive(0, 1, 1, 64'hBEEF, 64'h2, 5'd12);
        step("stall");
        chk("stall_alu", AluOut, 64'hA5);
        chk("stall_rw", 64'(RegWrite_Out), 64'd1);
        flush = 1'b1;
        drive(1, 0, 1, 64'h40, 64'h3, 5'd5);
        step("flush");
        chk("flush_alu", AluOut, 64'h40);
        chk("flush_mw", 64'(MemWrite_Out), 64'd0);
        reset = 1'b1;
        step("rst_over_flush");
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
`endif

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
            reset = ($urandom_range(0, 19) == 0);
`ifdef EX_MEM_HAZARD_EN
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0);
`endif
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the Execute (EX) and Memory (MEM) stages of the 5-stage 64-bit pipelined core. It captures the EX-stage control bits (RegWrite, MemtoReg, MemWrite), the ALU result, the store data and the destination register index on every rising clock edge. It presents them to the MEM stage one cycle later. An optional hazard interface adds stall (hold) and flush (bubble insertion).

## Interface
Parameters:
- DATA_W, 64, width of the ALU result and store-data paths.
- REG_W, 5, width of the destination register index.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all outputs.
- RegWrite  input  1  EX-stage register-file write enable.
- MemtoReg  input  1  EX-stage writeback select (1 = memory data).
- MemWrite  input  1  EX-stage data-memory write enable.
- AluResult  input  DATA_W  ALU result / memory address.
- Datain  input  DATA_W  store data (rs2 value).
- Rd_in  input  REG_W  destination register index.
- RegWrite_Out  output  1  registered RegWrite.
- MemtoReg_Out  output  1  registered MemtoReg.
- MemWrite_Out  output  1  registered MemWrite.
- AluOut  output  DATA_W  registered AluResult.
- DataOut  output  DATA_W  registered Datain.
- Rd_out  output  REG_W  registered Rd_in.
- stall  input  1  present only with EX_MEM_HAZARD_EN; hold current contents.
- flush  input  1  present only with EX_MEM_HAZARD_EN; insert bubble.

## Operation
- All outputs are driven directly from flip-flops. There is no combinational path from any input to any output.
- Reset: at a rising edge with reset=1, every output becomes 0: control bits 0, AluOut and DataOut all-zero, Rd_out = 0.
- Normal load: at a rising edge with reset=0, each output takes the value its input had at that edge.
- Data values pass unmodified at full width. There is no sign extension, truncation or arithmetic.
- Priority per edge: reset > flush > stall > load.
- Flush (hazard build):
  - RegWrite_Out, MemtoReg_Out and MemWrite_Out become 0.
  - AluOut, DataOut and Rd_out load their inputs normally.
  - The stage holds a harmless bubble: it causes no memory write and no register write.
- Stall (hazard build): all six outputs hold their previous values.
- Flush and stall both asserted: flush wins.
- Reset asserted together with stall or flush: reset wins; all outputs become 0.
- Rd_out = 0 is a legal value. The block applies no x0 special-casing; that is handled downstream.

## Timing
- Latency is exactly 1 cycle from input to output. Throughput is one transfer per cycle.
- Reset is sampled only at the clock edge. Asserting reset between edges does not change the outputs.
- Deasserting reset mid-operation: the first edge with reset=0 loads the inputs.
- Before the first reset edge, output values are undefined. Benches must apply reset for at least one edge.
- Inputs must be stable around the rising edge. No internal clock gating is used.

## Configuration
- Macro: EX_MEM_HAZARD_EN.
- Defined: the stall and flush input ports exist, with the behaviour given above.
- Undefined:
  - Those ports are absent.
  - The register loads unconditionally every cycle when reset=0.
  - The instantiation port list is exactly the 14 clock, reset, data and control ports.

## Test plan
- Reset then zero inputs: reset=1 for one edge, then reset=0 for one edge with all inputs 0 -> all six outputs read 0.
- Load all-ones: RegWrite=1, MemtoReg=1, MemWrite=1, AluResult=64'hFFFF_FFFF_FFFF_FFFF, Datain=64'hDEAD_BEEF_0123_4567, Rd_in=5'd31 -> identical values appear on the outputs after exactly one edge, not before.
- Back-to-back pipelining: apply Rd_in=1,2,3 on consecutive edges -> Rd_out reads 1,2,3 on the following consecutive edges, each lagging by one cycle.
- Mid-stream reset: outputs hold AluOut=64'h1234; assert reset for one edge with nonzero inputs -> all outputs become 0 at that edge; the next edge with reset=0 loads the inputs.
- Hazard build, stall: outputs hold AluOut=64'hA5 with RegWrite_Out=1; set stall=1 and change the inputs -> outputs remain 64'hA5 and 1.
- Hazard build, flush: set flush=1 (stall also 1) with RegWrite=1, MemWrite=1, AluResult=64'h40 -> control outputs read 0 and AluOut reads 64'h40.
